s2_capture_pool: RTL and testbench

- Downstream companion of the stage-2 convolution datapath.
- Sequences the stage-2 filter-select and position counter through all 4 filters × 36 output positions.
- Captures the addressed ReLU result into a 144-entry feature buffer each cycle, then performs 2×2/stride-2 max pooling.
- Streams the resulting 4×3×3 = 36 pooled values to the next stage over a valid/ready handshake.

---
 rtl/s2_capture_pool_pkg.sv | 25 ++
 rtl/s2_capture_pool_if.sv | 33 +++
 rtl/s2_capture_pool_max4_signed.sv | 30 +++
 rtl/s2_capture_pool.sv | 213 +++++++++++++++++++++
 tb/tb_s2_capture_pool.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/s2_capture_pool_pkg.sv
// -----------------------------------------------------------------------------
// s2_capture_pool_pkg
// Shared definitions for the stage-2 capture / max-pool block: geometry of the
// stage-2 output tensor, the controller state encoding and the signed result
// word type.
// -----------------------------------------------------------------------------
package s2_capture_pool_pkg;

  localparam int S2_NFILT    = 4;    // stage-2 filters
  localparam int S2_ODIM     = 6;    // side of one stage-2 output map
  localparam int S2_MAP      = 36;   // positions per output map
  localparam int S2_TOTAL    = 144;  // positions across all filters
  localparam int S2_POOL_MAP = 9;    // pooled positions per filter (3x3)
  localparam int S2_DWIDTH   = 35;   // signed stage-2 result width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_POOL = 2'd2,
    ST_OUT  = 2'd3
  } s2_state_e;

  typedef logic signed [S2_DWIDTH-1:0] s2_word_t;

endpackage

// File: rtl/s2_capture_pool_if.sv
// -----------------------------------------------------------------------------
// s2_capture_pool_if
// Valid/ready stream carrying pooled values to the next stage.
//   pool_data  : signed pooled value
//   pool_idx   : pooled index f*9 + pr*3 + pc
//   pool_valid : data/idx valid
//   pool_ready : consumer accepts the current value
// master = producer (s2_capture_pool), slave = consumer.
// -----------------------------------------------------------------------------
interface s2_capture_pool_if #(
  parameter int DWIDTH = s2_capture_pool_pkg::S2_DWIDTH
);

  logic signed [DWIDTH-1:0] pool_data;
  logic [5:0]               pool_idx;
  logic                     pool_valid;
  logic                     pool_ready;

  modport master (
    output pool_data,
    output pool_idx,
    output pool_valid,
    input  pool_ready
  );

  modport slave (
    input  pool_data,
    input  pool_idx,
    input  pool_valid,
    output pool_ready
  );

endinterface

// File: rtl/s2_capture_pool_max4_signed.sv
// -----------------------------------------------------------------------------
// max4_signed
// Combinational signed maximum of four DWIDTH-bit values (one 2x2 window).
//   a_i..d_i : signed window elements
//   max_o    : signed maximum
// Equal inputs are interchangeable, so ties need no selection rule.
// -----------------------------------------------------------------------------
module max4_signed
  import s2_capture_pool_pkg::*;
#(
  parameter int DWIDTH = S2_DWIDTH
) (
  input  logic signed [DWIDTH-1:0] a_i,
  input  logic signed [DWIDTH-1:0] b_i,
  input  logic signed [DWIDTH-1:0] c_i,
  input  logic signed [DWIDTH-1:0] d_i,
  output logic signed [DWIDTH-1:0] max_o
);

  logic signed [DWIDTH-1:0] m_ab_s;
  logic signed [DWIDTH-1:0] m_cd_s;

  // Two-level compare tree; all operands signed so negatives order correctly.
  always_comb begin
    m_ab_s = (a_i > b_i) ? a_i : b_i;
    m_cd_s = (c_i > d_i) ? c_i : d_i;
    max_o  = (m_ab_s > m_cd_s) ? m_ab_s : m_cd_s;
  end

endmodule

// File: rtl/s2_capture_pool.sv
// -----------------------------------------------------------------------------
// s2_capture_pool
// Drives the stage-2 filter-select / position counter through every output
// position, captures the addressed result into a feature buffer, then
// performs 2x2 / stride-2 max pooling and streams the pooled values out.
//
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   start        : one-cycle request, honoured only when idle
//   busy         : frame in progress
//   proc_dir     : filter select to stage 2
//   proc_counter : linear output position row*ODIM+col to stage 2
//   output_res   : stage-2 result vector (only the addressed element is used)
//   pool         : pooled value stream (master side)
//   done         : one-cycle pulse after the last pooled value is accepted
// -----------------------------------------------------------------------------
module s2_capture_pool
  import s2_capture_pool_pkg::*;
#(
  parameter int DWIDTH = S2_DWIDTH,
  parameter int NFILT  = S2_NFILT,
  parameter int ODIM   = S2_ODIM
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic [1:0]                              proc_dir,
  output logic [5:0]                              proc_counter,
  input  logic [NFILT*ODIM*ODIM-1:0][DWIDTH-1:0]  output_res,
  s2_capture_pool_if.master                       pool,
  output logic                                    done
);

  localparam int MAP   = ODIM * ODIM;
  localparam int TOTAL = NFILT * MAP;
  localparam int PHALF = ODIM / 2;
  localparam int PMAP  = PHALF * PHALF;

  localparam logic [1:0] LAST_DIR = 2'(NFILT - 1);
  localparam logic [5:0] LAST_CNT = 6'(MAP - 1);
  localparam logic [5:0] LAST_P   = 6'(NFILT * PMAP - 1);

  s2_state_e                state_q, state_d;
  logic [1:0]               dir_q, dir_d;
  logic [5:0]               cnt_q, cnt_d;
  logic [5:0]               p_q, p_d;
  logic                     busy_q, busy_d;
  logic signed [DWIDTH-1:0] pool_data_q, pool_data_d;
  logic [5:0]               pool_idx_q, pool_idx_d;
  logic                     pool_valid_q, pool_valid_d;
  logic                     done_q, done_d;

  logic signed [DWIDTH-1:0] fbuf_q [TOTAL];

  logic [7:0]               cap_addr_s;
  logic [5:0]               f_s;
  logic [5:0]               rem_s;
  logic [5:0]               pr_s;
  logic [5:0]               pc_s;
  logic [7:0]               win_a0_s;
  logic [7:0]               win_a1_s;
  logic [7:0]               win_a2_s;
  logic [7:0]               win_a3_s;
  logic signed [DWIDTH-1:0] win_max_s;

  // Capture address: stage 2 is combinational, so the element addressed by
  // the registered dir/cnt is valid in the same cycle.
  always_comb begin
    cap_addr_s = 8'(MAP) * {6'd0, dir_q} + {2'd0, cnt_q};
  end

  // Decompose the pool index into filter / pooled row / pooled column and
  // form the four window addresses of the 2x2 block.
  always_comb begin
    f_s      = p_q / 6'(PMAP);
    rem_s    = p_q % 6'(PMAP);
    pr_s     = rem_s / 6'(PHALF);
    pc_s     = rem_s % 6'(PHALF);
    win_a0_s = 8'(MAP) * {2'd0, f_s} + 8'(2 * ODIM) * {2'd0, pr_s} + {1'b0, pc_s, 1'b0};
    win_a1_s = win_a0_s + 8'd1;
    win_a2_s = win_a0_s + 8'(ODIM);
    win_a3_s = win_a2_s + 8'd1;
  end

  max4_signed #(
    .DWIDTH (DWIDTH)
  ) u_max4 (
    .a_i   (fbuf_q[win_a0_s]),
    .b_i   (fbuf_q[win_a1_s]),
    .c_i   (fbuf_q[win_a2_s]),
    .d_i   (fbuf_q[win_a3_s]),
    .max_o (win_max_s)
  );

  // Feature buffer: written only during CONV; contents need no reset since
  // every entry is rewritten before pooling reads it.
  always_ff @(posedge clk) begin
    if (state_q == ST_CONV) begin
      fbuf_q[cap_addr_s] <= output_res[cap_addr_s];
    end
  end

  // Next-state and output logic of the frame controller.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    busy_d       = busy_q;
    pool_data_d  = pool_data_q;
    pool_idx_d   = pool_idx_q;
    pool_valid_d = pool_valid_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONV;
          dir_d   = 2'd0;
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CONV: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = 6'd0;
          if (dir_q == LAST_DIR) begin
            // Last capture edge: dir returns to 0 so proc_dir/proc_counter
            // read 0 outside CONV.
            state_d = ST_POOL;
            dir_d   = 2'd0;
            p_d     = 6'd0;
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      ST_POOL: begin
        pool_data_d  = win_max_s;
        pool_idx_d   = p_q;
        pool_valid_d = 1'b1;
        state_d      = ST_OUT;
      end

      ST_OUT: begin
        if (pool.pool_ready) begin
          pool_valid_d = 1'b0;
          if (p_q == LAST_P) begin
            state_d = ST_IDLE;
            p_d     = 6'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_POOL;
            p_d     = p_q + 6'd1;
          end
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        dir_d        = 2'd0;
        cnt_d        = 6'd0;
        p_d          = 6'd0;
        busy_d       = 1'b0;
        pool_valid_d = 1'b0;
      end
    endcase
  end

  // Controller and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= 2'd0;
      cnt_q        <= 6'd0;
      p_q          <= 6'd0;
      busy_q       <= 1'b0;
      pool_data_q  <= '0;
      pool_idx_q   <= 6'd0;
      pool_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      busy_q       <= busy_d;
      pool_data_q  <= pool_data_d;
      pool_idx_q   <= pool_idx_d;
      pool_valid_q <= pool_valid_d;
      done_q       <= done_d;
    end
  end

  assign busy            = busy_q;
  assign proc_dir        = dir_q;
  assign proc_counter    = cnt_q;
  assign pool.pool_data  = pool_data_q;
  assign pool.pool_idx   = pool_idx_q;
  assign pool.pool_valid = pool_valid_q;
  assign done            = done_q;

endmodule

// File: tb/tb_s2_capture_pool.sv
// -----------------------------------------------------------------------------
// tb_s2_capture_pool
// Self-checking bench for s2_capture_pool. Stage 2 is modelled as a stored
// result array driven onto output_res; pooled values are predicted directly
// from the window definition (max over a 2x2 block of each 6x6 map).
// -----------------------------------------------------------------------------
module tb_s2_capture_pool;
  import s2_capture_pool_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  busy;
  logic [1:0]            proc_dir;
  logic [5:0]            proc_counter;
  logic [143:0][34:0]    output_res;
  logic                  done;

  s2_capture_pool_if pif ();

  s2_capture_pool dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .proc_dir     (proc_dir),
    .proc_counter (proc_counter),
    .output_res   (output_res),
    .pool         (pif),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [34:0] model_res [144];
  logic signed [34:0] got [36];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected pooled value for index k, straight from the window definition.
  function automatic logic signed [34:0] exp_pool(input int k);
    int f, pr, pc;
    logic signed [34:0] m, v;
    f  = k / 9;
    pr = (k % 9) / 3;
    pc = k % 3;
    m  = model_res[36 * f + (2 * pr) * 6 + 2 * pc];
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        v = model_res[36 * f + (2 * pr + dy) * 6 + 2 * pc + dx];
        if (v > m) m = v;
      end
    end
    return m;
  endfunction

  // kind 0: identity a->a; 1: random; 2: random with window 0 all negative.
  task automatic load_model(input int kind);
    for (int a = 0; a < 144; a++) begin
      if (kind == 0) model_res[a] = 35'(a);
      else           model_res[a] = 35'({$urandom, $urandom});
    end
    if (kind == 2) begin
      model_res[0] = -35'sd5;
      model_res[1] = -35'sd3;
      model_res[6] = -35'sd7;
      model_res[7] = -35'sd9;
    end
    for (int a = 0; a < 144; a++) output_res[a] = model_res[a];
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_dir"},   64'(proc_dir), 64'd0);
    chk({tag, "_cnt"},   64'(proc_counter), 64'd0);
    chk({tag, "_valid"}, 64'(pif.pool_valid), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
  endtask

  // One full frame. stress: random ready, stall at idx4, stray starts.
  task automatic run_frame(input bit identity, input bit stress);
    int  c, k, dones, stall, first_valid;
    bit  stalled;
    @(negedge clk);
    start = 1'b1;
    pif.pool_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0; k = 0; dones = 0; stall = 0; first_valid = -1; stalled = 1'b0;
    while (dones == 0 && c < 700) begin
      if (c < 144) begin
        chk("conv_dir",  64'(proc_dir), 64'(c / 36));
        chk("conv_cnt",  64'(proc_counter), 64'(c % 36));
        chk("conv_busy", 64'(busy), 64'd1);
      end else begin
        chk("post_dir", 64'(proc_dir), 64'd0);
        chk("post_cnt", 64'(proc_counter), 64'd0);
      end
      if (stalled) chk("stall_valid", 64'(pif.pool_valid), 64'd1);
      if (pif.pool_valid) begin
        if (first_valid < 0) first_valid = c;
        chk("pool_idx",  64'(pif.pool_idx), 64'(k));
        chk("pool_data", 64'(pif.pool_data), 64'(exp_pool(k)));
      end
      if (done) begin
        dones++;
        chk("done_after_last", 64'(k), 64'd36);
      end
      start = stress && (c == 20 || (k == 10 && pif.pool_valid));
      if (stress && pif.pool_valid && k == 4 && stall < 5) begin
        pif.pool_ready = 1'b0;
        stall++;
      end else if (stress) begin
        pif.pool_ready = ($urandom_range(0, 3) != 0);
      end else begin
        pif.pool_ready = 1'b1;
      end
      stalled = pif.pool_valid && !pif.pool_ready;
      if (pif.pool_valid && pif.pool_ready) begin
        if (k < 36) got[k] = pif.pool_data;
        k++;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_seen", 64'(dones), 64'd1);
    chk("out_count", 64'(k), 64'd36);
    chk("first_valid_cycle", 64'(first_valid), 64'd145);
    if (stress) chk("stall_cycles", 64'(stall), 64'd5);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) chk("done_single", 64'(done), 64'd0);
      chk("end_busy",  64'(busy), 64'd0);
      chk("end_valid", 64'(pif.pool_valid), 64'd0);
      @(negedge clk);
    end
    if (identity) begin
      chk("id_idx0",  64'(got[0]),  64'd7);
      chk("id_idx8",  64'(got[8]),  64'd35);
      chk("id_idx9",  64'(got[9]),  64'd43);
      chk("id_idx35", 64'(got[35]), 64'd143);
    end
  endtask

  // Start a frame and reset it asynchronously at CONV cycle 50.
  task automatic abort_frame();
    bit bad;
    @(negedge clk);
    start = 1'b1;
    pif.pool_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_pre_dir", 64'(proc_dir), 64'd1);
    chk("abort_pre_cnt", 64'(proc_counter), 64'd14);
    rst = 1'b1;
    #1;
    check_idle_outputs("abort_async");
    chk("abort_idx",  64'(pif.pool_idx), 64'd0);
    chk("abort_data", 64'(pif.pool_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (220) begin
      @(negedge clk);
      if (done || pif.pool_valid || busy) bad = 1'b1;
    end
    chk("abort_quiet", 64'(bad), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pif.pool_ready = 1'b0;
    output_res = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_idx",  64'(pif.pool_idx), 64'd0);
    chk("reset_data", 64'(pif.pool_data), 64'd0);
    rst = 1'b0;
    // Ready toggling while nothing is valid must have no effect.
    repeat (4) begin
      pif.pool_ready = ~pif.pool_ready;
      @(negedge clk);
      check_idle_outputs("idle_ready");
    end

    load_model(0);
    run_frame(1'b1, 1'b0);

    load_model(2);
    run_frame(1'b0, 1'b1);
    chk("signed_idx0", 64'(got[0]), -64'sd3);

    load_model(1);
    abort_frame();
    run_frame(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
